seg7_scan_decoder: RTL
======================

Name: seg7_scan_decoder

Overview:
- Reverse of the board's hex-to-7-segment path. Watches a time-multiplexed, active-low 7-segment display bus: segment lines plus active-low digit selects.
- Recovers the hex nibble shown on each digit and holds it in a per-digit register.
- Emits one valid/ready update event per committed digit change.
- Used as a readback/self-check monitor beside the display driver, and in benches.

Parameters:
- NUM_DIGITS, 4, number of scanned digits (1..8).
- STABLE_CYCLES, 4, consecutive identical samples needed before a digit is committed (2..255).
- IDX_W, 2, width of the digit index. Must be at least clog2(NUM_DIGITS), minimum 1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- seg_in  input  7  segment lines, active-low. Bit 0=a … bit 6=g.
- dig_sel_n  input  NUM_DIGITS  digit selects, active-low, expected one-hot-low.
- hex_out  output  4*NUM_DIGITS  decoded nibbles; digit k occupies [4k+3:4k].
- digit_valid  output  NUM_DIGITS  digit k holds a decoded value.
- upd_valid  output  1  update event pending.
- upd_ready  input  1  consumer accepts the event.
- upd_idx  output  IDX_W  digit index of the event.
- upd_nibble  output  4  nibble of the event.
- err_pattern  output  1  sticky flag: an unrecognised pattern was committed.
- err_overrun  output  1  sticky flag: an event was lost.
- clr_err  input  1  clears both sticky flags.

Behaviour:
- Reset: all outputs 0 (hex_out, digit_valid, upd_*, err_*). FSM goes to IDLE, sampler registers are cleared.
- Input path: seg_in and dig_sel_n pass through two register stages before use (synchroniser). Total latency from stable input to commit is 2 + STABLE_CYCLES cycles.
- Decode table (g..a, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1011000 or 1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110. 1111111 = blank. Any other pattern is invalid.
- IDLE: stay while dig_sel_n is not exactly one-low. On exactly one-low, latch the index and pattern, set count=1, go to TRACK.
- TRACK: each cycle, compare the sample against the latched (index, pattern).
  - Mismatch: if the new select is exactly one-low, relatch it and set count=1; otherwise go to IDLE.
  - Match: count+1. When count reaches STABLE_CYCLES, commit and go to HOLD.
- HOLD: stay while the sample matches. On any change, act as IDLE/TRACK entry in the same cycle. Holding a match never re-commits.
- Commit, valid pattern: write hex_out slice for the digit and set digit_valid[idx]. Raise an event only if the nibble differs from the stored one or digit_valid[idx] was 0.
- Commit, blank pattern: clear digit_valid[idx]. hex_out slice is unchanged. No event.
- Commit, invalid pattern: set err_pattern. hex_out and digit_valid are unchanged. No event.
- Event register (1 entry): upd_valid rises the cycle after commit. upd_idx and upd_nibble stay stable while upd_valid=1. A transfer happens when upd_valid && upd_ready; upd_valid drops the next cycle unless a new event loads in the same cycle.
- Event while full: if upd_valid=1, upd_ready=0, and a new event commits, the new event is dropped, err_overrun is set, and the held event is kept.
- Event on the transfer cycle: a commit in the same cycle as a transfer loads the new event with no loss.
- Sticky flags: clr_err clears them. If a set and clr_err happen in the same cycle, set wins.
- Reset mid-operation: all state returns to reset values in the next cycle, including any pending event.

Optional Feature:
- Macro SEG7_DP_EN.
- Defined:
  - Adds port dp_in (input, 1, active-low decimal point, synchronised like seg_in).
  - Adds port dp_out (output, NUM_DIGITS, dp state per digit).
  - Adds port upd_dp (output, 1, dp state of the event).
  - dp is part of the stability comparison. A dp-only change on a valid digit generates an event.
- Undefined: the dp ports are absent and the decimal point is ignored.

Test Plan:
- Reset with rst_n=0 for 2 cycles, inputs toggling -> all outputs 0 and no upd_valid during or after reset.
- dig_sel_n=1110 and seg_in=0110000 held 8 cycles, upd_ready=1 -> hex_out[3:0]=3, digit_valid=0001, single event idx=0 nibble=3, upd_valid high exactly 1 cycle.
- Scan digits 0..3 showing 1,A,b,F with 6 cycles each, STABLE_CYCLES=4 -> hex_out=16'hFBA1, digit_valid=1111, four events in order. A second identical scan produces no events.
- Select held only 3 cycles per digit -> no commits, and hex_out stays 0.
- seg_in=1010101 stable -> err_pattern=1 and no event. Then seg_in=1111111 on a valid digit -> its digit_valid bit clears. Then clr_err -> err_pattern=0.
- upd_ready=0 with two distinct commits -> first event held, err_overrun=1. Then upd_ready=1 -> the held event transfers and upd_valid=0 the next cycle.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// Readback monitor for a scanned, active-low 7-segment bus: recovers per-digit nibbles
// and emits one valid/ready event per committed change. Optional dp support: SEG7_DP_EN.
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int IDX_W         = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel_n,
`ifdef SEG7_DP_EN
  input  logic                    dp_in,
  output logic [NUM_DIGITS-1:0]   dp_out,
  output logic                    upd_dp,
`endif
  output logic [4*NUM_DIGITS-1:0] hex_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    upd_valid,
  input  logic                    upd_ready,
  output logic [IDX_W-1:0]        upd_idx,
  output logic [3:0]              upd_nibble,
  output logic                    err_pattern,
  output logic                    err_overrun,
  input  logic                    clr_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] TRACK = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  // Returns {valid, blank, nibble}; the pattern is g..a with segments lit low.
  function automatic logic [5:0] decode_seg(input logic [6:0] p);
    case (p)
      7'b1000000: decode_seg = 6'b10_0000;
      7'b1111001: decode_seg = 6'b10_0001;
      7'b0100100: decode_seg = 6'b10_0010;
      7'b0110000: decode_seg = 6'b10_0011;
      7'b0011001: decode_seg = 6'b10_0100;
      7'b0010010: decode_seg = 6'b10_0101;
      7'b0000010: decode_seg = 6'b10_0110;
      7'b1011000: decode_seg = 6'b10_0111;
      7'b1111000: decode_seg = 6'b10_0111;
      7'b0000000: decode_seg = 6'b10_1000;
      7'b0010000: decode_seg = 6'b10_1001;
      7'b0001000: decode_seg = 6'b10_1010;
      7'b0000011: decode_seg = 6'b10_1011;
      7'b1000110: decode_seg = 6'b10_1100;
      7'b0100001: decode_seg = 6'b10_1101;
      7'b0000110: decode_seg = 6'b10_1110;
      7'b0001110: decode_seg = 6'b10_1111;
      7'b1111111: decode_seg = 6'b01_0000;
      default:    decode_seg = 6'b00_0000;
    endcase
  endfunction

  logic [6:0]            seg_s1, seg_s2;
  logic [NUM_DIGITS-1:0] sel_s1, sel_s2;
  logic                  dp_smp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_s1 <= '0;
      seg_s2 <= '0;
      sel_s1 <= '0;
      sel_s2 <= '0;
    end else begin
      seg_s1 <= seg_in;
      seg_s2 <= seg_s1;
      sel_s1 <= dig_sel_n;
      sel_s2 <= sel_s1;
    end
  end

`ifdef SEG7_DP_EN
  logic dp_s1, dp_s2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dp_s1 <= 1'b0;
      dp_s2 <= 1'b0;
    end else begin
      dp_s1 <= dp_in;
      dp_s2 <= dp_s1;
    end
  end

  assign dp_smp = dp_s2;
`else
  assign dp_smp = 1'b1;
`endif

  logic [3:0]       zeros;
  logic             sel_onehot;
  logic [IDX_W-1:0] sel_idx;

  always_comb begin
    zeros   = 4'd0;
    sel_idx = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (!sel_s2[k]) begin
        zeros   = zeros + 4'd1;
        sel_idx = IDX_W'(k);
      end
    end
    sel_onehot = (zeros == 4'd1);
  end

  logic [1:0]            state, state_nx;
  logic [7:0]            count, count_nx;
  logic [NUM_DIGITS-1:0] lat_sel, lat_sel_nx;
  logic [6:0]            lat_seg, lat_seg_nx;
  logic                  lat_dp, lat_dp_nx;
  logic [IDX_W-1:0]      lat_idx, lat_idx_nx;
  logic                  match, commit;

  assign match = (sel_s2 == lat_sel) && (seg_s2 == lat_seg) && (dp_smp == lat_dp);

  // Any change of the sample restarts tracking at once when a single digit is selected.
  always_comb begin
    state_nx   = state;
    count_nx   = count;
    lat_sel_nx = lat_sel;
    lat_seg_nx = lat_seg;
    lat_dp_nx  = lat_dp;
    lat_idx_nx = lat_idx;
    commit     = 1'b0;
    if ((state == TRACK && match) || (state == HOLD && match)) begin
      if (state == TRACK) begin
        count_nx = count + 8'd1;
        if (count + 8'd1 == 8'(STABLE_CYCLES)) begin
          commit   = 1'b1;
          state_nx = HOLD;
        end
      end
    end else if (sel_onehot) begin
      lat_sel_nx = sel_s2;
      lat_seg_nx = seg_s2;
      lat_dp_nx  = dp_smp;
      lat_idx_nx = sel_idx;
      count_nx   = 8'd1;
      state_nx   = TRACK;
    end else begin
      state_nx = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      lat_sel <= '0;
      lat_seg <= '0;
      lat_dp  <= 1'b0;
      lat_idx <= '0;
    end else begin
      state   <= state_nx;
      count   <= count_nx;
      lat_sel <= lat_sel_nx;
      lat_seg <= lat_seg_nx;
      lat_dp  <= lat_dp_nx;
      lat_idx <= lat_idx_nx;
    end
  end

  logic [5:0] dec;
  logic       dec_valid, dec_blank;
  logic [3:0] dec_nib;
  logic [3:0] old_nib;
  logic       old_valid;
  logic       new_evt;

  assign dec       = decode_seg(lat_seg);
  assign dec_valid = dec[5];
  assign dec_blank = dec[4];
  assign dec_nib   = dec[3:0];

`ifdef SEG7_DP_EN
  logic old_dp;
`endif

  always_comb begin
    old_nib   = 4'd0;
    old_valid = 1'b0;
`ifdef SEG7_DP_EN
    old_dp    = 1'b0;
`endif
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (lat_idx == IDX_W'(k)) begin
        old_nib   = hex_out[4*k +: 4];
        old_valid = digit_valid[k];
`ifdef SEG7_DP_EN
        old_dp    = dp_out[k];
`endif
      end
    end
  end

`ifdef SEG7_DP_EN
  assign new_evt = commit && dec_valid &&
                   (!old_valid || (old_nib != dec_nib) || (old_dp != !lat_dp));
`else
  assign new_evt = commit && dec_valid && (!old_valid || (old_nib != dec_nib));
`endif

  // Blank patterns only retire the digit; the stored nibble is kept for reference.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hex_out     <= '0;
      digit_valid <= '0;
    end else if (commit) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (lat_idx == IDX_W'(k)) begin
          if (dec_valid) begin
            hex_out[4*k +: 4] <= dec_nib;
            digit_valid[k]    <= 1'b1;
          end else if (dec_blank) begin
            digit_valid[k] <= 1'b0;
          end
        end
      end
    end
  end

`ifdef SEG7_DP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dp_out <= '0;
    end else if (commit && dec_valid) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (lat_idx == IDX_W'(k)) dp_out[k] <= !lat_dp;
      end
    end
  end
`endif

  // Single-entry event register; a commit during a transfer reuses the slot without loss.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      upd_valid  <= 1'b0;
      upd_idx    <= '0;
      upd_nibble <= '0;
`ifdef SEG7_DP_EN
      upd_dp     <= 1'b0;
`endif
    end else if (new_evt && (!upd_valid || upd_ready)) begin
      upd_valid  <= 1'b1;
      upd_idx    <= lat_idx;
      upd_nibble <= dec_nib;
`ifdef SEG7_DP_EN
      upd_dp     <= !lat_dp;
`endif
    end else if (upd_valid && upd_ready) begin
      upd_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_pattern <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (commit && !dec_valid && !dec_blank) err_pattern <= 1'b1;
      else if (clr_err)                       err_pattern <= 1'b0;
      if (new_evt && upd_valid && !upd_ready) err_overrun <= 1'b1;
      else if (clr_err)                       err_overrun <= 1'b0;
    end
  end

endmodule
